// File: rtl/mux_scan_sel_if.sv
// Channel-select bus between the switch/GPIO side and the LED/7-seg drivers.
// The master drives the selection controls; the slave (the selector) returns the registered channel data.
interface mux_scan_sel_if #(
    parameter int NR_CH    = 4,
    parameter int DATA_LEN = 2
);
    localparam int SEL_W = $clog2(NR_CH);

    logic [NR_CH*DATA_LEN-1:0] din;
    logic [SEL_W-1:0]          sel;
    logic                      mode;
    logic [NR_CH-1:0]          en_mask;
    logic                      hold;
    logic [DATA_LEN-1:0]       dout;
    logic [SEL_W-1:0]          cur_ch;
    logic                      dout_valid;
    logic                      ch_change;

    modport master (
        output din, sel, mode, en_mask, hold,
        input  dout, cur_ch, dout_valid, ch_change
    );

    modport slave (
        input  din, sel, mode, en_mask, hold,
        output dout, cur_ch, dout_valid, ch_change
    );
endinterface

// File: rtl/mux_scan_sel.sv
// Registered NR_CH:1 channel selector with a manual select mode and an auto-scan mode.
// state     | meaning
// ST_MANUAL | cur_ch follows sel on every non-hold cycle
// ST_SCAN   | cur_ch steps to the next enabled channel every SCAN_DIV cycles
module mux_scan_sel #(
    parameter int                  NR_CH    = 4,
    parameter int                  DATA_LEN = 2,
    parameter int                  SCAN_DIV = 8,
    parameter logic [DATA_LEN-1:0] DEFAULT  = '0
) (
    input logic           clk,
    input logic           rst,
    mux_scan_sel_if.slave bus
);
    localparam int SEL_W = $clog2(NR_CH);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(SCAN_DIV - 1);

    typedef enum logic {ST_MANUAL, ST_SCAN} state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    cur_q, cur_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [DATA_LEN-1:0] dout_q, dout_d;
    logic                valid_q, valid_d;
    logic                chg_q, chg_d;

    logic [SEL_W-1:0]    hi_ch, lo_ch, scan_nxt;
    logic                hi_hit, lo_hit;
    logic [DATA_LEN-1:0] sel_data;
    logic                sel_en;

    // Next enabled channel above cur_q, else the lowest enabled one (may be cur_q itself).
    always_comb begin
        hi_ch  = cur_q;
        lo_ch  = cur_q;
        hi_hit = 1'b0;
        lo_hit = 1'b0;
        for (int j = NR_CH - 1; j >= 0; j--) begin
            if (bus.en_mask[j]) begin
                if (j > int'(cur_q)) begin
                    hi_ch  = SEL_W'(j);
                    hi_hit = 1'b1;
                end else begin
                    lo_ch  = SEL_W'(j);
                    lo_hit = 1'b1;
                end
            end
        end
        scan_nxt = hi_hit ? hi_ch : (lo_hit ? lo_ch : cur_q);
    end

    // A mode change wins over a scan advance landing on the same edge.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        div_d   = div_q;
        if (!bus.hold) begin
            case (state_q)
                ST_MANUAL: begin
                    if (bus.mode) begin
                        state_d = ST_SCAN;
                        div_d   = '0;
                    end else begin
                        cur_d = bus.sel;
                    end
                end
                ST_SCAN: begin
                    if (!bus.mode) begin
                        state_d = ST_MANUAL;
                        cur_d   = bus.sel;
                        div_d   = '0;
                    end else if (div_q == DIV_TC) begin
                        div_d = '0;
                        cur_d = scan_nxt;
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
                default: state_d = ST_MANUAL;
            endcase
        end
    end

    always_comb begin
        sel_data = DEFAULT;
        sel_en   = 1'b0;
        for (int j = 0; j < NR_CH; j++) begin
            if (int'(cur_d) == j) begin
                sel_data = bus.din[j*DATA_LEN +: DATA_LEN];
                sel_en   = bus.en_mask[j];
            end
        end
    end

    always_comb begin
        dout_d  = dout_q;
        valid_d = valid_q;
        chg_d   = 1'b0;
        if (!bus.hold) begin
            dout_d  = sel_en ? sel_data : DEFAULT;
            valid_d = sel_en;
            chg_d   = (cur_d != cur_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_MANUAL;
            cur_q   <= '0;
            div_q   <= '0;
            dout_q  <= DEFAULT;
            valid_q <= 1'b0;
            chg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            div_q   <= div_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            chg_q   <= chg_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.cur_ch     = cur_q;
    assign bus.dout_valid = valid_q;
    assign bus.ch_change  = chg_q;
endmodule

// File: tb/tb_mux_scan_sel.sv
// Directed bench for mux_scan_sel: the driver queues hand-computed expectations,
// and a monitor pops one expectation per clock and compares it with the registered outputs.
module tb_mux_scan_sel;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mux_scan_sel_if #(.NR_CH(4), .DATA_LEN(2)) bus ();

    mux_scan_sel #(
        .NR_CH(4), .DATA_LEN(2), .SCAN_DIV(4), .DEFAULT(2'b00)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [1:0] dout;
        logic [1:0] ch;
        logic       v;
        logic       chg;
    } exp_t;

    exp_t exp_q[$];
    int   vec_cnt = 0;
    int   err_cnt = 0;
    int   mon_idx = 0;
    logic [1:0] seq [4] = '{2'd0, 2'd2, 2'd3, 2'd0};

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        vec_cnt++;
        if (act !== req) begin
            err_cnt++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Apply one input vector for the coming rising edge and queue what must appear after it.
    task automatic drive(input logic [7:0] din, input logic [1:0] sel, input logic mode,
                         input logic [3:0] en, input logic hold,
                         input logic [1:0] e_d, input logic [1:0] e_c,
                         input logic e_v, input logic e_g);
        exp_t e;
        bus.din     = din;
        bus.sel     = sel;
        bus.mode    = mode;
        bus.en_mask = en;
        bus.hold    = hold;
        e.dout = e_d;
        e.ch   = e_c;
        e.v    = e_v;
        e.chg  = e_g;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        exp_t got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {bus.dout, bus.cur_ch, bus.dout_valid, bus.ch_change};
                vec_cnt++;
                if (got !== e) begin
                    err_cnt++;
                    $display("FAIL vec%0d: got dout=%0d cur_ch=%0d valid=%0b chg=%0b, required dout=%0d cur_ch=%0d valid=%0b chg=%0b",
                             mon_idx, got.dout, got.ch, got.v, got.chg, e.dout, e.ch, e.v, e.chg);
                end
                mon_idx++;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        bus.din     = 8'hE4;
        bus.sel     = 2'd2;
        bus.mode    = 1'b0;
        bus.en_mask = 4'hF;
        bus.hold    = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_dout",   8'(bus.dout),       8'd0);
        check("rst_cur_ch", 8'(bus.cur_ch),     8'd0);
        check("rst_valid",  8'(bus.dout_valid), 8'd0);
        check("rst_chg",    8'(bus.ch_change),  8'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // release, then manual sweep over din = E4 (ch0..3 = 0,1,2,3)
        drive(8'hE4, 2'd2, 1'b0, 4'hF, 1'b0, 2'd2, 2'd2, 1'b1, 1'b1);
        drive(8'hE4, 2'd2, 1'b0, 4'hF, 1'b0, 2'd2, 2'd2, 1'b1, 1'b0);
        drive(8'hE4, 2'd0, 1'b0, 4'hF, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1);
        drive(8'hE4, 2'd1, 1'b0, 4'hF, 1'b0, 2'd1, 2'd1, 1'b1, 1'b1);
        drive(8'hE4, 2'd2, 1'b0, 4'hF, 1'b0, 2'd2, 2'd2, 1'b1, 1'b1);
        drive(8'hE4, 2'd3, 1'b0, 4'hF, 1'b0, 2'd3, 2'd3, 1'b1, 1'b1);
        drive(8'hE4, 2'd2, 1'b0, 4'b1011, 1'b0, 2'd0, 2'd2, 1'b0, 1'b1);
        drive(8'hE4, 2'd2, 1'b0, 4'b1011, 1'b0, 2'd0, 2'd2, 1'b0, 1'b0);
        drive(8'h1B, 2'd2, 1'b0, 4'hF,    1'b0, 2'd1, 2'd2, 1'b1, 1'b0);
        drive(8'hE4, 2'd0, 1'b0, 4'hF,    1'b0, 2'd0, 2'd0, 1'b1, 1'b1);

        // scan with ch1 disabled: 0,2,3,0 each shown 4 cycles
        for (int n = 0; n < 16; n++)
            drive(8'hE4, 2'd0, 1'b1, 4'b1101, 1'b0, seq[n/4], seq[n/4], 1'b1,
                  ((n % 4) == 0) && (n != 0));

        // single enabled channel: one hop to ch2, then no further pulses
        drive(8'hE4, 2'd0, 1'b1, 4'b0100, 1'b0, 2'd2, 2'd2, 1'b1, 1'b1);
        repeat (8) drive(8'hE4, 2'd0, 1'b1, 4'b0100, 1'b0, 2'd2, 2'd2, 1'b1, 1'b0);

        // all disabled: DEFAULT, invalid, cur_ch frozen while the divider runs on
        repeat (6) drive(8'hE4, 2'd0, 1'b1, 4'h0, 1'b0, 2'd0, 2'd2, 1'b0, 1'b0);

        // hold mid-dwell on ch3 after one dwell cycle
        drive(8'hE4, 2'd0, 1'b1, 4'hF, 1'b0, 2'd2, 2'd2, 1'b1, 1'b0);
        drive(8'hE4, 2'd0, 1'b1, 4'hF, 1'b0, 2'd3, 2'd3, 1'b1, 1'b1);
        drive(8'hE4, 2'd0, 1'b1, 4'hF, 1'b0, 2'd3, 2'd3, 1'b1, 1'b0);
        for (int n = 0; n < 6; n++)
            drive((n % 2) ? 8'h1B : 8'h00, 2'd0, 1'b1, 4'hF, 1'b1, 2'd3, 2'd3, 1'b1, 1'b0);
        drive(8'hE4, 2'd0, 1'b1, 4'hF, 1'b0, 2'd3, 2'd3, 1'b1, 1'b0);
        drive(8'hE4, 2'd0, 1'b1, 4'hF, 1'b0, 2'd3, 2'd3, 1'b1, 1'b0);
        drive(8'hE4, 2'd0, 1'b1, 4'hF, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1);
        repeat (3) drive(8'hE4, 2'd0, 1'b1, 4'hF, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0);
        drive(8'hE4, 2'd0, 1'b1, 4'hF, 1'b0, 2'd1, 2'd1, 1'b1, 1'b1);
        repeat (3) drive(8'hE4, 2'd0, 1'b1, 4'hF, 1'b0, 2'd1, 2'd1, 1'b1, 1'b0);

        // SCAN->MANUAL on the terminal-count edge: sel=1 wins over the advance to 2
        drive(8'hE4, 2'd1, 1'b0, 4'hF, 1'b0, 2'd1, 2'd1, 1'b1, 1'b0);
        drive(8'hE4, 2'd3, 1'b0, 4'hF, 1'b0, 2'd3, 2'd3, 1'b1, 1'b1);

        @(negedge clk);
        @(negedge clk);
        check("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/mux_scan_sel.md
# mux_scan_sel

Parametrised, registered N-channel selector with manual and auto-scan modes, the successor to the fixed 4:1 key-selected mux that drives the board LEDs from the switches. It selects one DATA_LEN-bit channel out of NR_CH and outputs it through a register. The channel comes either from the `sel` input or from an internal scanner that rotates through the enabled channels every SCAN_DIV cycles. It sits between the switch/GPIO inputs and the LED/seven-segment drivers in the NPC top level.

## Interface
- NR_CH, 4: number of input channels (2..16)
- DATA_LEN, 2: bits per channel
- SCAN_DIV, 8: clock cycles each channel is shown in scan mode (≥2)
- DEFAULT, 0: value driven on `dout` when no valid channel is selected
- SEL_W = $clog2(NR_CH): derived width of the `sel` and `cur_ch` ports; not overridable
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- din  in  NR_CH*DATA_LEN  packed channels; channel i occupies bits [i*DATA_LEN +: DATA_LEN]
- sel  in  SEL_W  manual channel select
- mode  in  1  0 = MANUAL, 1 = SCAN
- en_mask  in  NR_CH  per-channel enable; bit i = 0 excludes channel i
- hold  in  1  freezes all state and outputs while high
- dout  out  DATA_LEN  registered selected data
- cur_ch  out  SEL_W  channel currently shown on `dout`
- dout_valid  out  1  1 when `dout` carries a real, enabled channel
- ch_change  out  1  one-cycle pulse when `cur_ch` takes a new value

## Operation
- Reset (async, rst=1) forces:
  - state = MANUAL
  - cur_ch = 0
  - divider = 0
  - dout = DEFAULT
  - dout_valid = 0
  - ch_change = 0
- State machine: state follows `mode`, registered, with two states MANUAL and SCAN. `mode` is sampled every non-hold cycle.
  - MANUAL→SCAN: the scan starts from the current `cur_ch` and the divider clears to 0.
  - SCAN→MANUAL: `sel` takes effect on the same edge that registers the transition.
- MANUAL:
  - next cur_ch = `sel`.
  - If `sel` ≥ NR_CH or en_mask[sel] = 0: next dout = DEFAULT and dout_valid = 0. `cur_ch` still records `sel` truncated to SEL_W.
- SCAN:
  - The divider counts 0..SCAN_DIV-1 and wraps.
  - At terminal count, cur_ch advances to the next enabled channel in increasing index order, wrapping NR_CH-1→0. Disabled channels are skipped within the same cycle.
  - If the current channel is the only enabled one, cur_ch stays and ch_change does not pulse.
  - If en_mask = 0 (all disabled): cur_ch holds, dout = DEFAULT, dout_valid = 0, and the divider keeps counting.
  - If the current channel becomes disabled mid-dwell, `dout` goes to DEFAULT with dout_valid = 0 until the next advance.
- Data path, every non-hold cycle:
  - dout ← din slice of next cur_ch.
  - dout_valid ← (next cur_ch < NR_CH) && en_mask[next cur_ch].
  - Data therefore tracks `din` continuously, not only on channel change.
- ch_change ← (next cur_ch ≠ cur_ch) in non-hold cycles, 0 otherwise.
- hold = 1 freezes state, divider, cur_ch, dout and dout_valid, and forces ch_change = 0. On release, operation resumes from the frozen divider value.
- Simultaneous events:
  - hold has priority over mode change and terminal count.
  - A mode change takes priority over a scan advance in the same cycle.
  - rst has priority over everything.

## Timing
- Latency is 1 cycle. A value of `din`/`sel` present before edge N appears on `dout`/`cur_ch` after edge N.
- `cur_ch`, `dout`, `dout_valid` and `ch_change` are all registered and mutually aligned. No combinational path runs from an input to any output.
- In SCAN with k enabled channels, each channel is shown for exactly SCAN_DIV cycles, for a full period of k*SCAN_DIV cycles.
- ch_change is high for exactly one cycle per change and never during hold.
- Reset deasserted mid-scan restarts at channel 0 in MANUAL. The first valid `dout` appears one edge after release.

## Test plan
All scenarios use NR_CH=4, DATA_LEN=2, SCAN_DIV=4.
- Reset: assert rst with din=8'hE4 → dout=0, dout_valid=0, cur_ch=0, ch_change=0 immediately (asynchronous). After release with mode=0, sel=2, en_mask=4'hF → one edge later dout=2'b10, cur_ch=2, ch_change=1 for one cycle.
- Manual sweep: din=8'hE4, sel stepped 0,1,2,3 one per cycle → dout=0,1,2,3 each lagging one cycle. Then en_mask=4'b1011 with sel=2 → dout=0, dout_valid=0.
- Scan rotation and skip: mode=1, en_mask=4'b1101, start at cur_ch=0 → cur_ch sequence 0,2,3,0,... with each value held 4 cycles and ch_change pulsing once per advance.
- Degenerate scan masks:
  - en_mask=4'b0100 → cur_ch stays 2, no ch_change pulses.
  - en_mask=0 → dout=0, dout_valid=0, cur_ch frozen.
- Hold: hold=1 for 6 cycles mid-dwell while din toggles → dout, cur_ch and divider unchanged, ch_change=0. After release, the remaining dwell completes before the next advance.
- Mode switch collision: switch SCAN→MANUAL with sel=1 on the same cycle as the divider terminal count → cur_ch=1 next edge, no scan advance.
